seg7_reader: RTL and testbench
==============================

# seg7_reader

Sampling decoder for the 7-segment display path. It watches an active-low segment bus plus a minus-sign indicator and filters out transient patterns. Each stable pattern is converted back into the 5-bit two's-complement value (-16..+15) that the display decoder renders, and reported once over a valid/ready handshake. It sits on the readback/self-check side of the display subsystem, feeding the value checker.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a pattern is accepted; legal range 1..15.
- clk  in  1  single system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- seg_in  in  7  segment bus, active-low: bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- sign_in  in  1  minus indicator; 1 means negative.
- sample_en  in  1  sample strobe; sign_in/seg_in are considered only on edges where this is 1.
- out_ready  in  1  consumer accepts the result.
- out_valid  out  1  result pending.
- out_value  out  5  decoded two's-complement value.
- out_error  out  1  accepted pattern is not a legal encoding.

## Operation
- Pattern-to-magnitude map (seg_in, bits 6..0):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, 10=0001000, 11=1100000, 12=0110001, 13=1000010, 14=0110000, 15=0111000
  - 16=0100001
- Value rules:
  - sign_in=0, magnitude 0..15: out_value = magnitude.
  - sign_in=1, magnitude 1..16: out_value = (32 - magnitude) mod 32. Examples: -1 gives 11111, -16 gives 10000.
  - Error cases: any unlisted pattern, +16, and -0 (sign_in=1 with the 0 pattern). Each gives out_error=1 and out_value=00000.
- Internal state:
  - last: 8-bit register holding the last sampled {sign_in, seg_in}.
  - cnt: saturating 0..STABLE_CYCLES.
  - rep: 8-bit register holding the last reported {sign, seg}.
- FSM states: TRACK, PRESENT, LOCKED.
- TRACK, on each sample_en edge:
  - If cnt==0 or the sample differs from last: last <= sample, cnt <= 1.
  - Otherwise: cnt <= cnt+1.
  - When the new cnt equals STABLE_CYCLES: decode the sample, load out_value/out_error, set rep <= sample and out_valid <= 1, and go to PRESENT.
  - With STABLE_CYCLES=1, the first sample is reported.
- PRESENT:
  - out_valid, out_value and out_error are held stable; samples are ignored.
  - On an edge with out_ready=1: out_valid <= 0, go to LOCKED.
- LOCKED:
  - A sample equal to rep is discarded; the same pattern is never reported twice in a row.
  - The first sample different from rep sets last <= sample, cnt <= 1, and goes to TRACK. If STABLE_CYCLES=1, it instead reports immediately and goes to PRESENT.
- Reset (asynchronous, any state, any cycle): state=TRACK, cnt=0, last=0, rep=0, out_valid=0, out_value=00000, out_error=0. A pending result is discarded.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency, with sample_en held high and the input constant:
  - out_valid rises on the STABLE_CYCLES-th rising edge after the input settles (edge 4 by default).
  - out_value and out_error are valid in the same cycle as out_valid.
- Handshake:
  - Transfer occurs on an edge with out_valid=1 and out_ready=1; out_valid is 0 after that edge.
  - out_ready is ignored while out_valid=0.
  - Minimum gap between two reports is STABLE_CYCLES edges after the handshake.
- sample_en low: cnt and last are held. Gaps in sampling do not break a run.
- A sample that differs restarts the run at cnt=1 on that same edge; there is no partial credit.

## Test plan
- Basic report: reset, STABLE_CYCLES=4, sign_in=0, seg_in=0100100, sample_en=1, out_ready=1. Expect out_valid high on edge 4 for exactly one cycle, with out_value=00101 and out_error=0. Holding the input afterwards produces no further reports.
- Negative range: sign_in=1 with seg_in=1001111, then 0100001, then 0110001, each stable for 4 samples. Expect reports 11111, 10000 and 10100 in order.
- Bounce rejection: seg_in alternates 0000110 and 0001111 every 2 samples for 20 cycles. Expect out_valid to stay 0. Then hold 0001111; expect 00111 on the 4th sample.
- Errors: seg_in=1111111 gives out_error=1 with out_value=00000. sign_in=1 with 0000001 gives out_error=1. sign_in=0 with 0100001 gives out_error=1.
- Backpressure: report 3 (00011), hold out_ready=0 for 10 cycles while seg_in changes to 0000100. Expect out_value to stay 00011 throughout. Raise out_ready for one cycle; next, 9 (01001) is reported 4 samples after the handshake.
- Reset mid-run: pull rst_n low after 3 matching samples. Expect all outputs 0 immediately. After release, 4 fresh samples are needed before a report.

Source files
------------

// File: rtl/seg7_reader.sv
// Readback decoder for the 7-segment path: debounces {sign, seg} samples and reports
// each newly stable pattern once as a 5-bit two's-complement value over valid/ready.
module seg7_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic       sign_in,
  input  logic       sample_en,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [4:0] out_value,
  output logic       out_error
);

  typedef enum logic [1:0] {TRACK, PRESENT, LOCKED} state_t;

  localparam logic [3:0] SC = 4'(STABLE_CYCLES);

  state_t     state, state_n;
  logic [7:0] last, last_n, rep, rep_n, sample;
  logic [3:0] cnt, cnt_n, run_cnt;
  logic       valid_n, err_n;
  logic [4:0] value_n;
  logic [5:0] dec;

  assign sample = {sign_in, seg_in};

  // Returns {error, value}; errors always carry a zero value.
  function automatic logic [5:0] decode(input logic [7:0] s);
    logic [4:0] mag;
    logic [4:0] neg;
    logic       ok;
    ok  = 1'b1;
    mag = 5'd0;
    case (s[6:0])
      7'b0000001: mag = 5'd0;
      7'b1001111: mag = 5'd1;
      7'b0010010: mag = 5'd2;
      7'b0000110: mag = 5'd3;
      7'b1001100: mag = 5'd4;
      7'b0100100: mag = 5'd5;
      7'b0100000: mag = 5'd6;
      7'b0001111: mag = 5'd7;
      7'b0000000: mag = 5'd8;
      7'b0000100: mag = 5'd9;
      7'b0001000: mag = 5'd10;
      7'b1100000: mag = 5'd11;
      7'b0110001: mag = 5'd12;
      7'b1000010: mag = 5'd13;
      7'b0110000: mag = 5'd14;
      7'b0111000: mag = 5'd15;
      7'b0100001: mag = 5'd16;
      default:    ok  = 1'b0;
    endcase
    neg = 5'd0 - mag;
    if (!ok || (!s[7] && mag == 5'd16) || (s[7] && mag == 5'd0))
      return {1'b1, 5'd0};
    return {1'b0, s[7] ? neg : mag};
  endfunction

  assign dec = decode(sample);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= TRACK;
      last      <= '0;
      rep       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_value <= '0;
      out_error <= 1'b0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      rep       <= rep_n;
      cnt       <= cnt_n;
      out_valid <= valid_n;
      out_value <= value_n;
      out_error <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    last_n  = last;
    rep_n   = rep;
    cnt_n   = cnt;
    valid_n = out_valid;
    value_n = out_value;
    err_n   = out_error;
    run_cnt = '0;
    case (state)
      TRACK: begin
        if (sample_en) begin
          if (cnt == 4'd0 || sample != last) begin
            last_n  = sample;
            run_cnt = 4'd1;
          end else begin
            run_cnt = (cnt >= SC) ? SC : cnt + 4'd1;
          end
          cnt_n = run_cnt;
          if (run_cnt == SC) begin
            valid_n          = 1'b1;
            {err_n, value_n} = dec;
            rep_n            = sample;
            state_n          = PRESENT;
          end
        end
      end
      PRESENT: begin
        if (out_ready) begin
          valid_n = 1'b0;
          state_n = LOCKED;
        end
      end
      LOCKED: begin
        // Only a pattern different from the one just reported restarts tracking.
        if (sample_en && sample != rep) begin
          last_n  = sample;
          cnt_n   = 4'd1;
          state_n = TRACK;
          if (SC == 4'd1) begin
            valid_n          = 1'b1;
            {err_n, value_n} = dec;
            rep_n            = sample;
            state_n          = PRESENT;
          end
        end
      end
      default: state_n = TRACK;
    endcase
  end

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a debounce/report model built from the rules.
module tb_seg7_reader;
  localparam int SC = 4;

  logic       clk, rst_n;
  logic [6:0] seg_in;
  logic       sign_in, sample_en, out_ready;
  logic       out_valid, out_error;
  logic [4:0] out_value;

  int n_cmp = 0;
  int n_fail = 0;

  seg7_reader #(.STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .sign_in(sign_in),
    .sample_en(sample_en), .out_ready(out_ready), .out_valid(out_valid),
    .out_value(out_value), .out_error(out_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] pat [17] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
                           7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000,
                           7'b0111000, 7'b0100001};

  // Model: a streak of identical accepted samples; a report blocks its own pattern
  // until some other pattern shows up.
  logic       m_valid, m_err, blocked;
  logic [4:0] m_val;
  logic [7:0] m_pat, m_rep;
  int         streak;

  function automatic void mdec(input logic s, input logic [6:0] g,
                               output logic [4:0] v, output logic e);
    int mag, val;
    mag = -1;
    for (int i = 0; i < 17; i++) if (pat[i] == g) mag = i;
    val = s ? -mag : mag;
    e = (mag < 0) || (val > 15) || (s && mag == 0);
    v = e ? 5'd0 : 5'(val & 31);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_err = 0; m_val = 0; blocked = 0;
    m_pat = 0; m_rep = 0; streak = 0;
  endtask

  task automatic model_edge();
    logic [7:0] s;
    if (!rst_n) return;
    s = {sign_in, seg_in};
    if (m_valid) begin
      if (out_ready) m_valid = 0;
    end else if (sample_en && !(blocked && s == m_rep)) begin
      blocked = 0;
      if (streak > 0 && s == m_pat) streak++;
      else begin m_pat = s; streak = 1; end
      if (streak >= SC) begin
        mdec(s[7], s[6:0], m_val, m_err);
        m_valid = 1; m_rep = s; blocked = 1; streak = 0;
      end
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    n_cmp++;
    if (out_valid !== m_valid || (m_valid && (out_value !== m_val || out_error !== m_err))) begin
      n_fail++;
      $display("FAIL model: dut v=%b val=%b err=%b expected v=%b val=%b err=%b at %0t",
               out_valid, out_value, out_error, m_valid, m_val, m_err, $time);
    end
  end

  task automatic step(input logic s, input logic [6:0] g, input logic en, input logic rdy);
    sign_in = s; seg_in = g; sample_en = en; out_ready = rdy;
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic feed(input logic s, input logic [6:0] g, input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(s, g, 1'b1, rdy);
  endtask

  task automatic expect_out(input string name, input logic v, input logic [4:0] val, input logic e);
    chk({name, ".valid"}, int'(out_valid), int'(v));
    if (v) begin
      chk({name, ".value"}, int'(out_value), int'(val));
      chk({name, ".error"}, int'(out_error), int'(e));
    end
  endtask

  int seen;
  int hold;
  logic [6:0] rg;
  logic rs;

  initial begin
    rst_n = 0; seg_in = 0; sign_in = 0; sample_en = 0; out_ready = 0;
    model_reset();
    #1;
    expect_out("reset", 1'b0, 5'd0, 1'b0);
    chk("reset.value0", int'(out_value), 0);
    #16 rst_n = 1;

    // Basic report
    feed(0, 7'b0100100, 3, 1);
    expect_out("basic.edge3", 0, 0, 0);
    feed(0, 7'b0100100, 1, 1);
    expect_out("basic", 1, 5'b00101, 0);
    feed(0, 7'b0100100, 1, 1);
    expect_out("basic.oneshot", 0, 0, 0);
    feed(0, 7'b0100100, 5, 1);
    expect_out("basic.noreport", 0, 0, 0);

    // Negative range
    feed(1, 7'b1001111, 4, 1);
    expect_out("neg1", 1, 5'b11111, 0);
    feed(1, 7'b0100001, 5, 1);
    expect_out("neg16", 1, 5'b10000, 0);
    feed(1, 7'b0110001, 5, 1);
    expect_out("neg12", 1, 5'b10100, 0);

    // Bounce rejection: pairs start with 7 so the trailing pair is 3
    seen = 0;
    for (int p = 0; p < 10; p++)
      for (int k = 0; k < 2; k++) begin
        step(0, p[0] ? 7'b0000110 : 7'b0001111, 1, 1);
        if (out_valid) seen++;
      end
    chk("bounce.noreport", seen, 0);
    feed(0, 7'b0001111, 3, 1);
    expect_out("bounce.hold3", 0, 0, 0);
    feed(0, 7'b0001111, 1, 1);
    expect_out("bounce.hold", 1, 5'b00111, 0);

    // Errors
    feed(0, 7'b1111111, 5, 1);
    expect_out("err.blank", 1, 5'b00000, 1);
    feed(1, 7'b0000001, 5, 1);
    expect_out("err.minus0", 1, 5'b00000, 1);
    feed(0, 7'b0100001, 5, 1);
    expect_out("err.plus16", 1, 5'b00000, 1);

    // Backpressure
    feed(0, 7'b0000110, 5, 1);
    expect_out("bp.three", 1, 5'b00011, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 7'b0000100, 1, 0);
      if (!out_valid || out_value != 5'b00011) seen++;
    end
    chk("bp.held", seen, 0);
    feed(0, 7'b0000100, 1, 1);
    expect_out("bp.handshake", 0, 0, 0);
    feed(0, 7'b0000100, 3, 1);
    expect_out("bp.early", 0, 0, 0);
    feed(0, 7'b0000100, 1, 1);
    expect_out("bp.nine", 1, 5'b01001, 0);

    // Reset mid-run
    feed(0, 7'b0100000, 4, 1);
    rst_n = 0;
    model_reset();
    #1;
    chk("rst.valid", int'(out_valid), 0);
    chk("rst.value", int'(out_value), 0);
    chk("rst.error", int'(out_error), 0);
    @(posedge clk);
    #2 rst_n = 1;
    feed(0, 7'b0100000, 3, 1);
    expect_out("rst.fresh3", 0, 0, 0);
    feed(0, 7'b0100000, 1, 1);
    expect_out("rst.fresh", 1, 5'b00110, 0);

    // Random phase against the model
    for (int n = 0; n < 300; n++) begin
      rg = ($urandom_range(0, 9) == 0) ? 7'(($urandom_range(0, 127))) : pat[$urandom_range(0, 16)];
      rs = 1'($urandom_range(0, 3) == 0);
      hold = $urandom_range(1, 7);
      for (int k = 0; k < hold; k++)
        step(rs, rg, 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 9) < 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
